lcd_reader: RTL and testbench
=============================

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter CLK_DIV, default 50000, clk cycles per LCD timing tick (>=2).
REQ-002 Parameter POLL_MAX, default 255, maximum status reads per poll request before timeout (1..255).
REQ-003 Port clk input 1, system clock; the block SHALL use one clock.
REQ-004 Port rst input 1, reset; the block SHALL treat it as synchronous and active-high.
REQ-005 Port req input 1, single-cycle request; accepted only when ready=1.
REQ-006 Port req_sel input 2, 00=one status read (RS=0), 01=one DDRAM data read (RS=1), 10=poll status until BF=0, 11=reserved, treated as 00.
REQ-007 Port ready output 1, high in IDLE only.
REQ-008 Port rd_valid output 1, one-clk pulse when rd_byte is updated.
REQ-009 Port rd_byte output 8, last byte read, {high nibble, low nibble}.
REQ-010 Port busy_flag output 1, rd_byte[7] of the last status read.
REQ-011 Port addr_cnt output 7, rd_byte[6:0] of the last status read.
REQ-012 Port rs, rw, e output 1 each, LCD control pins.
REQ-013 Port db_in input 4, LCD DB7..DB4 as seen by FPGA.
REQ-014 Port db_oe output 1, FPGA drive enable for DB7..DB4; SHALL be 0 whenever rw=1.

Function
REQ-015 Tick: free-running counter 0..CLK_DIV-1; tick is asserted for one clk when the count equals CLK_DIV-1. All state changes except request acceptance occur on tick.
REQ-016 States: IDLE, SETUP, HI_E1, HI_E0, LO_E1, LO_E0, DONE.
REQ-017 IDLE: ready=1, e=0, rw=0, db_oe=0. A request with req=1 is latched on that clk, and the state goes to SETUP.
REQ-018 SETUP (1 tick): rs=req_sel[0] (0 for poll), rw=1, e=0, db_oe=0.
REQ-019 HI_E1 (1 tick): e=1. The high nibble is sampled from db_in on the tick clk that leaves HI_E1.
REQ-020 HI_E0 (1 tick): e=0.
REQ-021 LO_E1 (1 tick): e=1. The low nibble is sampled on the tick clk that leaves LO_E1.
REQ-022 LO_E0 (1 tick): e=0.
REQ-023 DONE: on the first clk in DONE, rd_byte is updated and rd_valid pulses.
REQ-024 busy_flag and addr_cnt update from a status read only; a data read leaves them unchanged.
REQ-025 Exit from DONE, single read: go to IDLE on the next tick with rw=0.
REQ-026 Exit from DONE, poll: if BF=0, go to IDLE; if BF=1, go to SETUP.
REQ-027 Request latency: accept to rd_valid is 5 ticks plus up to 1 clk, counted from the first tick after acceptance.
REQ-028 A req while ready=0 is ignored and is not queued.
REQ-029 rs and rw are held stable throughout each E pulse; rw changes only while e=0.

Reset
REQ-030 With rst=1, the state goes to IDLE, the tick counter goes to 0, and the poll counter goes to 0.
REQ-031 Reset values: rs=0, rw=0, e=0, db_oe=0, rd_valid=0, rd_byte=0, busy_flag=0, addr_cnt=0, ready=1 from the clk after reset.
REQ-032 rst asserted mid-read aborts the read immediately; no rd_valid is produced.

Configuration
REQ-033 Macro LCD_READER_POLL_TIMEOUT_EN.
- Defined: poll mode counts completed reads. Reaching POLL_MAX with BF=1 returns to IDLE, raises output timeout_err (1 bit), and holds it until the next accepted req or rst.
- Undefined: the timeout_err port is absent, and poll repeats indefinitely.

Structure
REQ-034 Package lcd_pkg holds the state enum, the req_sel encodings, and the default CLK_DIV. These are shared with the LCD writer.
REQ-035 Sub-module lcd_tick_gen (parameter CLK_DIV, outputs tick) provides the timing tick.

Verification
REQ-036 CLK_DIV=4, req_sel=00, db_in=4'h3 then 4'hA -> rd_byte=8'h3A, busy_flag=0, addr_cnt=7'h3A, rd_valid pulses exactly once.
REQ-037 req_sel=01, LCD model returns 8'h41 -> rd_byte=8'h41, rs=1 throughout, busy_flag/addr_cnt unchanged.
REQ-038 req_sel=10, model BF=1 for 3 reads then BF=0 -> 4 rd_valid pulses, ready only after the 4th, final busy_flag=0.
REQ-039 LCD_READER_POLL_TIMEOUT_EN, POLL_MAX=3, BF stuck 1 -> 3 reads, timeout_err=1, ready=1.
REQ-040 rst asserted during LO_E1 -> next clk: e=0, rw=0, ready=1, no rd_valid, rd_byte=0.
REQ-041 req pulsed during a read -> ignored; exactly one rd_valid; e-high duration = CLK_DIV clks; db_oe=0 whenever rw=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: controller state encoding, request selects and default timing.
// Used by both the LCD reader and the LCD writer.
package lcd_pkg;

  localparam int unsigned LCD_CLK_DIV_DEFAULT = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HI_E1,
    ST_HI_E0,
    ST_LO_E1,
    ST_LO_E0,
    ST_DONE
  } lcd_state_e;

  typedef enum logic [1:0] {
    SEL_STATUS = 2'b00,
    SEL_DATA   = 2'b01,
    SEL_POLL   = 2'b10,
    SEL_RSVD   = 2'b11
  } lcd_sel_e;

  // The reserved select behaves as a plain status read.
  function automatic lcd_sel_e sel_decode(input logic [1:0] raw);
    lcd_sel_e sel;
    sel = lcd_sel_e'(raw);
    if (sel == SEL_RSVD) sel = SEL_STATUS;
    return sel;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Host-side request/response bus of the LCD reader.
// Optional timeout_err exists only with LCD_READER_POLL_TIMEOUT_EN.
interface lcd_reader_if;

  logic       req;
  logic [1:0] req_sel;
  logic       ready;
  logic       rd_valid;
  logic [7:0] rd_byte;
  logic       busy_flag;
  logic [6:0] addr_cnt;
`ifdef LCD_READER_POLL_TIMEOUT_EN
  logic       timeout_err;

  modport master (
    output req, req_sel,
    input  ready, rd_valid, rd_byte, busy_flag, addr_cnt, timeout_err
  );

  modport slave (
    input  req, req_sel,
    output ready, rd_valid, rd_byte, busy_flag, addr_cnt, timeout_err
  );
`else
  modport master (
    output req, req_sel,
    input  ready, rd_valid, rd_byte, busy_flag, addr_cnt
  );

  modport slave (
    input  req, req_sel,
    output ready, rd_valid, rd_byte, busy_flag, addr_cnt
  );
`endif

endinterface

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-clk tick every CLK_DIV clocks,
// asserted while the count sits at CLK_DIV-1.
module lcd_tick_gen
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = LCD_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("lcd_tick_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style 4-bit read engine: status, DDRAM data and busy-poll reads.
// Optional poll timeout (timeout_err) enabled by defining LCD_READER_POLL_TIMEOUT_EN.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = LCD_CLK_DIV_DEFAULT,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  lcd_reader_if.slave bus,
  output logic        rs,
  output logic        rw,
  output logic        e,
  input  logic [3:0]  db_in,
  output logic        db_oe
);

  generate
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_poll_max
      $error("lcd_reader: POLL_MAX must be within 1..255");
    end
  endgenerate

  lcd_state_e state, state_nx;
  lcd_sel_e   sel_q;
  logic       tick;
  logic       ready;
  logic       accept;
  logic       poll_q;
  logic       rs_q;
  logic       poll_expired;
  logic [3:0] hi_q;
  logic [3:0] lo_q;
  logic [7:0] rd_byte;
  logic       rd_valid;
  logic       busy_flag;
  logic [6:0] addr_cnt;

  lcd_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign accept = (state == ST_IDLE) && bus.req;
  assign poll_q = (sel_q == SEL_POLL);
  assign rs_q   = (sel_q == SEL_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    rs       = 1'b0;
    rw       = 1'b1;
    e        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready = 1'b1;
        rw    = 1'b0;
        if (bus.req) state_nx = ST_SETUP;
      end
      ST_SETUP: begin
        rs = rs_q;
        if (tick) state_nx = ST_HI_E1;
      end
      ST_HI_E1: begin
        rs = rs_q;
        e  = 1'b1;
        if (tick) state_nx = ST_HI_E0;
      end
      ST_HI_E0: begin
        rs = rs_q;
        if (tick) state_nx = ST_LO_E1;
      end
      ST_LO_E1: begin
        rs = rs_q;
        e  = 1'b1;
        if (tick) state_nx = ST_LO_E0;
      end
      ST_LO_E0: begin
        rs = rs_q;
        if (tick) state_nx = ST_DONE;
      end
      ST_DONE: begin
        rs = rs_q;
        // busy_flag already reflects this read: it was loaded on entry to DONE.
        if (tick) begin
          if (poll_q && busy_flag && !poll_expired) state_nx = ST_SETUP;
          else                                      state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= SEL_STATUS;
      hi_q      <= '0;
      lo_q      <= '0;
      rd_byte   <= '0;
      rd_valid  <= 1'b0;
      busy_flag <= 1'b0;
      addr_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) sel_q <= sel_decode(bus.req_sel);
      if (tick) begin
        if (state == ST_HI_E1) hi_q <= db_in;
        if (state == ST_LO_E1) lo_q <= db_in;
        if (state == ST_LO_E0) begin
          rd_byte  <= {hi_q, lo_q};
          rd_valid <= 1'b1;
          if (sel_q != SEL_DATA) begin
            busy_flag <= hi_q[3];
            addr_cnt  <= {hi_q[2:0], lo_q};
          end
        end
      end
    end
  end

`ifdef LCD_READER_POLL_TIMEOUT_EN
  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

  logic [7:0] poll_cnt;
  logic       timeout_err;

  assign poll_expired    = (poll_cnt >= POLL_LIMIT);
  assign bus.timeout_err = timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      poll_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (tick && poll_q) begin
      if (state == ST_LO_E0) poll_cnt <= poll_cnt + 1'b1;
      if (state == ST_DONE && busy_flag && poll_expired) timeout_err <= 1'b1;
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  // The reader never drives the LCD data bus.
  assign db_oe = 1'b0;

  assign bus.ready     = ready;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_byte   = rd_byte;
  assign bus.busy_flag = busy_flag;
  assign bus.addr_cnt  = addr_cnt;

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader with a nibble-serving LCD model.
// Timeout scenario is exercised when LCD_READER_POLL_TIMEOUT_EN is defined.
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int unsigned CLK_DIV = 4;

  typedef struct {
    logic [7:0] data;
    logic       bf;
    logic [6:0] ac;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs, rw, e, db_oe;
  logic [3:0] db_in = 4'h0;
  logic [7:0] lcd_byte;
  bit         phase;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned pulse_cnt = 0;
  int unsigned e_run     = 0;
  int unsigned e_len     = 0;
  int unsigned oe_viol   = 0;
  int unsigned ctl_viol  = 0;
  logic        e_prev = 1'b0, rs_prev = 1'b0, rw_prev = 1'b0;

  lcd_reader_if bus();

  lcd_reader #(
    .CLK_DIV  (CLK_DIV),
    .POLL_MAX (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .rs    (rs),
    .rw    (rw),
    .e     (e),
    .db_in (db_in),
    .db_oe (db_oe)
  );

  always #5 clk = ~clk;

  // LCD model: high nibble on the first E pulse, low nibble on the second; rw low restarts.
  always @(posedge e or negedge rw) begin
    if (!rw) begin
      phase = 1'b0;
    end else if (!phase) begin
      db_in = lcd_byte[7:4];
      phase = 1'b1;
    end else begin
      db_in = lcd_byte[3:0];
      phase = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.rd_valid) pulse_cnt <= pulse_cnt + 1;
    if (e) begin
      e_run <= e_run + 1;
    end else if (e_run != 0) begin
      e_len <= e_run;
      e_run <= 0;
    end
    if (rw && db_oe) oe_viol <= oe_viol + 1;
    if (e && e_prev && (rs != rs_prev || rw != rw_prev)) ctl_viol <= ctl_viol + 1;
    e_prev  <= e;
    rs_prev <= rs;
    rw_prev <= rw;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] data, input logic bf, input logic [6:0] ac);
    exp_t x;
    x.data = data;
    x.bf   = bf;
    x.ac   = ac;
    exp_q.push_back(x);
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!bus.ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] sel);
    wait_ready("issue");
    bus.req     = 1'b1;
    bus.req_sel = sel;
    @(negedge clk);
    bus.req     = 1'b0;
    bus.req_sel = 2'b00;
  endtask

  // Waits for rd_valid and scores it; reports whether ready was seen and the rs levels seen under E.
  task automatic expect_read(input string tag, output bit saw_ready, output logic [1:0] rs_seen);
    bit   got = 1'b0;
    exp_t x;
    saw_ready = 1'b0;
    rs_seen   = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        got = 1'b1;
        break;
      end
      if (bus.ready) saw_ready = 1'b1;
      if (e) rs_seen[rs] = 1'b1;
    end
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    if (got) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        x = exp_q.pop_front();
        check({tag, "_byte"}, {24'd0, bus.rd_byte}, {24'd0, x.data});
        check({tag, "_bf"}, {31'd0, bus.busy_flag}, {31'd0, x.bf});
        check({tag, "_ac"}, {25'd0, bus.addr_cnt}, {25'd0, x.ac});
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    bit          sr;
    logic [1:0]  rsm;
    int unsigned p0;
    int unsigned rises;
    bit          found;
    logic [7:0]  poll_bytes [4];

    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.req_sel = 2'b00;
    lcd_byte    = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_pins", {28'd0, rs, rw, e, db_oe}, 32'd0);
    check("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_byte", {24'd0, bus.rd_byte}, 32'd0);
    check("rst_status", {24'd0, bus.busy_flag, bus.addr_cnt}, 32'd0);

    // Status read 0x3A
    lcd_byte = 8'h3A;
    push_exp(8'h3A, 1'b0, 7'h3A);
    p0 = pulse_cnt;
    issue(2'b00);
    expect_read("stat3a", sr, rsm);
    check("stat3a_rs", {30'd0, rsm}, 32'd1);
    wait_ready("stat3a");
    check("stat3a_pulses", pulse_cnt - p0, 32'd1);
    check("stat3a_elen", e_len, CLK_DIV);
    check("stat3a_idle_rw", {31'd0, rw}, 32'd0);

    // Reserved select behaves as status read, BF=1
    lcd_byte = 8'hC5;
    push_exp(8'hC5, 1'b1, 7'h45);
    issue(2'b11);
    expect_read("rsvd", sr, rsm);
    check("rsvd_rs", {30'd0, rsm}, 32'd1);

    // Data read leaves busy_flag/addr_cnt untouched
    lcd_byte = 8'h41;
    push_exp(8'h41, 1'b1, 7'h45);
    issue(2'b01);
    expect_read("data41", sr, rsm);
    check("data41_rs", {30'd0, rsm}, 32'd2);
    check("data41_rs_done", {31'd0, rs}, 32'd1);
    wait_ready("data41");

`ifdef LCD_READER_POLL_TIMEOUT_EN
    // BF stuck high: three reads then timeout
    lcd_byte = 8'h80;
    for (int k = 0; k < 3; k++) push_exp(8'h80, 1'b1, 7'h00);
    p0 = pulse_cnt;
    issue(2'b10);
    for (int k = 0; k < 3; k++) begin
      expect_read("tmo", sr, rsm);
      check("tmo_no_ready", {31'd0, sr}, 32'd0);
    end
    wait_ready("tmo");
    repeat (4 * CLK_DIV) @(negedge clk);
    check("tmo_pulses", pulse_cnt - p0, 32'd3);
    check("tmo_err", {31'd0, bus.timeout_err}, 32'd1);
    check("tmo_ready", {31'd0, bus.ready}, 32'd1);
    lcd_byte = 8'h22;
    push_exp(8'h22, 1'b0, 7'h22);
    issue(2'b00);
    check("tmo_err_clr", {31'd0, bus.timeout_err}, 32'd0);
    expect_read("tmo_after", sr, rsm);
    wait_ready("tmo_after");
`else
    // Poll: BF=1 for three reads, then BF=0
    poll_bytes = '{8'h85, 8'h86, 8'h87, 8'h07};
    push_exp(8'h85, 1'b1, 7'h05);
    push_exp(8'h86, 1'b1, 7'h06);
    push_exp(8'h87, 1'b1, 7'h07);
    push_exp(8'h07, 1'b0, 7'h07);
    lcd_byte = poll_bytes[0];
    p0 = pulse_cnt;
    issue(2'b10);
    for (int k = 0; k < 4; k++) begin
      expect_read("poll", sr, rsm);
      check("poll_no_ready", {31'd0, sr}, 32'd0);
      if (k < 3) lcd_byte = poll_bytes[k + 1];
    end
    wait_ready("poll");
    check("poll_pulses", pulse_cnt - p0, 32'd4);
    check("poll_bf", {31'd0, bus.busy_flag}, 32'd0);
`endif

    // req during a read is dropped
    lcd_byte = 8'h12;
    push_exp(8'h12, 1'b0, 7'h12);
    p0 = pulse_cnt;
    issue(2'b00);
    repeat (6) @(negedge clk);
    bus.req     = 1'b1;
    bus.req_sel = 2'b01;
    @(negedge clk);
    bus.req     = 1'b0;
    bus.req_sel = 2'b00;
    expect_read("busyreq", sr, rsm);
    wait_ready("busyreq");
    repeat (40) @(negedge clk);
    check("busyreq_pulses", pulse_cnt - p0, 32'd1);
    check("busyreq_elen", e_len, CLK_DIV);

    // Reset in LO_E1 aborts the read
    lcd_byte = 8'h55;
    p0 = pulse_cnt;
    issue(2'b00);
    rises = 0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (e && !e_prev) rises++;
      if (rises == 2) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_lo_e1", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pins", {29'd0, e, rw, bus.ready}, 32'd1);
    check("abort_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("abort_byte", {24'd0, bus.rd_byte}, 32'd0);
    check("abort_status", {24'd0, bus.busy_flag, bus.addr_cnt}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_pulses", pulse_cnt - p0, 32'd0);

    // Recovery after abort
    lcd_byte = 8'hBF;
    push_exp(8'hBF, 1'b1, 7'h3F);
    issue(2'b00);
    expect_read("recover", sr, rsm);
    wait_ready("recover");

    check("oe_while_rw", oe_viol, 32'd0);
    check("ctl_under_e", ctl_viol, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
